// File: rtl/hermitian_pkg.sv
// Shared constants and state type for the Hermitian strip writer.
// Defaults give 3 symbols x 255 kept bins packed into a 768-word buffer.
package hermitian_pkg;

    localparam int FFT_N     = 512;
    localparam int SYMS      = 3;
    localparam int KEEP_BINS = FFT_N/2 - 1;
    localparam int DEPTH     = 768;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;

    typedef enum logic {
        FILL     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/hermitian_addr_gen.sv
// Bin/symbol counters and packed write-address generation for the strip writer.
// Produces the keep decode plus end-of-symbol and end-of-frame flags.
module hermitian_addr_gen #(
    parameter int FFT_N  = hermitian_pkg::FFT_N,
    parameter int SYMS   = hermitian_pkg::SYMS,
    parameter int ADDR_W = hermitian_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              last,
    output logic              keep,
    output logic [ADDR_W-1:0] addr,
    output logic              last_bin,
    output logic              eos,
    output logic              eof
);
    import hermitian_pkg::*;

    localparam int KEEP  = FFT_N/2 - 1;
    localparam int BIN_W = $clog2(FFT_N);
    localparam int SYM_W = (SYMS > 1) ? $clog2(SYMS) : 1;

    logic [BIN_W-1:0]  bin;
    logic [SYM_W-1:0]  sym;
    logic [ADDR_W-1:0] base;

    // base tracks sym*KEEP so the address needs only an adder
    always_comb begin
        last_bin = (bin == BIN_W'(FFT_N - 1));
        keep     = (bin != '0) && (bin <= BIN_W'(KEEP));
        addr     = base + ADDR_W'(bin) - ADDR_W'(1);
        eos      = beat && (last_bin || last);
        eof      = eos && (sym == SYM_W'(SYMS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            sym  <= '0;
            base <= '0;
        end else if (beat) begin
            if (eos) begin
                bin <= '0;
                if (eof) begin
                    sym  <= '0;
                    base <= '0;
                end else begin
                    sym  <= sym + 1'b1;
                    base <= base + ADDR_W'(KEEP);
                end
            end else begin
                bin <= bin + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermitian_strip_writer.sv
// Fill stage of the Hermitian-remover buffer: keeps bins 1..FFT_N/2-1 of each symbol.
// Optional FRAME_CNT_EN macro adds a 16-bit count of completed frames (frame_cnt).
module hermitian_strip_writer #(
    parameter int FFT_N  = hermitian_pkg::FFT_N,
    parameter int SYMS   = hermitian_pkg::SYMS,
    parameter int DATA_W = hermitian_pkg::DATA_W,
    parameter int ADDR_W = hermitian_pkg::ADDR_W,
    parameter int DEPTH  = hermitian_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              err_len
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);
    import hermitian_pkg::*;

    if (SYMS * (FFT_N/2 - 1) > DEPTH) begin : g_depth_check
        $error("hermitian_strip_writer: frame does not fit in buffer");
    end

    state_t            state;
    state_t            state_next;
    logic              beat;
    logic              keep;
    logic              last_bin;
    logic              eos;
    logic              eof;
    logic [ADDR_W-1:0] wr_addr;

    assign beat        = s_axis_tvalid && s_axis_tready;
    assign frame_ready = (state == WAIT_ACK);

    hermitian_addr_gen #(
        .FFT_N  (FFT_N),
        .SYMS   (SYMS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .beat     (beat),
        .last     (s_axis_tlast),
        .keep     (keep),
        .addr     (wr_addr),
        .last_bin (last_bin),
        .eos      (eos),
        .eof      (eof)
    );

    always_comb begin
        state_next = state;
        case (state)
            FILL:     if (eof)       state_next = WAIT_ACK;
            WAIT_ACK: if (frame_ack) state_next = FILL;
            default:                 state_next = FILL;
        endcase
    end

    // tready follows the next state so it drops in the same cycle frame_ready rises
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_next;
            s_axis_tready <= (state_next == FILL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_di   <= '0;
            err_len   <= 1'b0;
        end else begin
            bram_en <= beat && keep;
            bram_we <= beat && keep;
            err_len <= eos && (s_axis_tlast != last_bin);
            if (beat && keep) begin
                bram_addr <= wr_addr;
                bram_di   <= s_axis_tdata;
            end
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == FILL && state_next == WAIT_ACK) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hermitian_strip_writer.sv
// Self-checking bench for hermitian_strip_writer against a bin/symbol arithmetic model.
// Covers full frames, tvalid gaps, early/late tlast, mid-frame reset and the ack hold.
module tb_hermitian_strip_writer;

    localparam int FFT_N  = 512;
    localparam int SYMS   = 3;
    localparam int KEEP   = FFT_N/2 - 1;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 768;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_di;
    logic              frame_ready;
    logic              frame_ack;
    logic              err_len;
`ifdef FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    always #5 clk = ~clk;

    hermitian_strip_writer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_di       (bram_di),
        .frame_ready   (frame_ready),
        .frame_ack     (frame_ack),
        .err_len       (err_len)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt     (frame_cnt)
`endif
    );

    int                checks   = 0;
    int                failures = 0;
    int                err_cnt  = 0;
    int                exp_err  = 0;
    int                fc_exp   = 0;
    logic [31:0]       wr_q[$];
    logic [31:0]       exp_q[$];
    logic [DATA_W-1:0] mem [DEPTH];

    // Observed buffer writes and error pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (bram_en === 1'b1 && bram_we === 1'b1) begin
            wr_q.push_back({6'b0, bram_addr, bram_di});
            if (int'(bram_addr) < DEPTH) mem[bram_addr] = bram_di;
        end
        if (err_len === 1'b1) err_cnt++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic l);
        bit taken;
        int guard;
        taken = 1'b0;
        guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!taken && guard < 64) begin
            taken = (s_axis_tready === 1'b1);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!taken) begin
            checks++;
            failures++;
            $error("[TB] FAIL accept_timeout observed=stalled expected=accepted");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idleCycle();
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One symbol of len beats; kept bin b of symbol s lands at s*KEEP + b - 1
    task automatic sendSymbol(input int sym, input int len, input bit with_last,
                              input bit gaps, input bit rnd);
        logic [DATA_W-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = rnd ? DATA_W'($urandom) : DATA_W'(b | (sym << 12));
            if (gaps) while ($urandom_range(1, 0) == 1) idleCycle();
            applyStimulus(d, with_last && (b == len - 1));
            if (b >= 1 && b <= KEEP) exp_q.push_back({6'b0, ADDR_W'(sym * KEEP + b - 1), d});
        end
        if ((with_last && len != FFT_N) || (!with_last && len == FFT_N)) exp_err++;
    endtask

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            checkOutput({tag, "_write"}, wr_q[i], exp_q[i]);
        checkOutput({tag, "_err_pulses"}, 32'(err_cnt), 32'(exp_err));
        wr_q.delete();
        exp_q.delete();
        err_cnt = 0;
        exp_err = 0;
    endtask

    task automatic finishFrame(input string tag);
        fc_exp++;
        checkOutput({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
        checkOutput({tag, "_tready_low"}, 32'(s_axis_tready), 32'd0);
`ifdef FRAME_CNT_EN
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc_exp));
`endif
        @(posedge clk);
        #1;
        compareWrites(tag);
    endtask

    task automatic ackFrame(input int hold);
        int ready_seen;
        ready_seen    = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hBEEF;
        for (int i = 0; i < hold; i++) begin
            if (s_axis_tready !== 1'b0) ready_seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("wait_tready_high_cycles", 32'(ready_seen), 32'd0);
        checkOutput("wait_frame_ready", 32'(frame_ready), 32'd1);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack     = 1'b0;
        s_axis_tvalid = 1'b0;
        checkOutput("wait_writes", 32'(wr_q.size()), 32'd0);
        checkOutput("ack_tready", 32'(s_axis_tready), 32'd1);
        checkOutput("ack_frame_ready", 32'(frame_ready), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        checkOutput({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        checkOutput({tag, "_bram_we"}, 32'(bram_we), 32'd0);
        checkOutput({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
        checkOutput({tag, "_bram_di"}, 32'(bram_di), 32'd0);
        checkOutput({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        checkOutput({tag, "_err_len"}, 32'(err_len), 32'd0);
`ifdef FRAME_CNT_EN
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        frame_ack     = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_tready", 32'(s_axis_tready), 32'd1);

        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        checkOutput("fill_ack_tready", 32'(s_axis_tready), 32'd1);
        checkOutput("fill_ack_frame_ready", 32'(frame_ready), 32'd0);

        $display("[TB] frame 1: gap-free pattern data");
        for (int s = 0; s < SYMS; s++) sendSymbol(s, FFT_N, 1'b1, 1'b0, 1'b0);
        finishFrame("frame1");
        checkOutput("mem_addr0", 32'(mem[0]), 32'h0001);
        checkOutput("mem_addr255", 32'(mem[255]), 32'h1001);
        checkOutput("mem_addr764", 32'(mem[764]), 32'h20FF);
        ackFrame(20);

        $display("[TB] frame 2: random tvalid gaps");
        for (int s = 0; s < SYMS; s++) sendSymbol(s, FFT_N, 1'b1, 1'b1, 1'b0);
        finishFrame("gaps");
        ackFrame(3);

        $display("[TB] frame 3: early tlast at bin 100");
        sendSymbol(0, 101, 1'b1, 1'b0, 1'b0);
        checkOutput("early_err_len", 32'(err_len), 32'd1);
        sendSymbol(1, FFT_N, 1'b1, 1'b0, 1'b1);
        sendSymbol(2, FFT_N, 1'b1, 1'b0, 1'b1);
        finishFrame("early");
        ackFrame(2);

        $display("[TB] frame 4: missing tlast in symbol 1");
        sendSymbol(0, FFT_N, 1'b1, 1'b0, 1'b1);
        sendSymbol(1, FFT_N, 1'b0, 1'b0, 1'b1);
        checkOutput("late_err_len", 32'(err_len), 32'd1);
        sendSymbol(2, FFT_N, 1'b1, 1'b0, 1'b1);
        finishFrame("late");
        ackFrame(2);

        $display("[TB] reset at beat 300 of symbol 1");
        sendSymbol(0, FFT_N, 1'b1, 1'b0, 1'b1);
        sendSymbol(1, 300, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midreset");
        compareWrites("aborted");
        fc_exp = 0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_release_tready", 32'(s_axis_tready), 32'd1);

        $display("[TB] frames 5-6: after reset, random data");
        for (int s = 0; s < SYMS; s++) sendSymbol(s, FFT_N, 1'b1, 1'b0, 1'b1);
        finishFrame("after_reset");
        ackFrame(2);
        for (int s = 0; s < SYMS; s++) sendSymbol(s, FFT_N, 1'b1, 1'b1, 1'b1);
        finishFrame("final");
        ackFrame(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
